// File: rtl/ram_cache_mp_pkg.sv
// Shared types and limits for the multi-port single-word read cache in front of one RAM port.
package ram_cache_mp_pkg;

    localparam int NPORTS_MIN = 2;
    localparam int NPORTS_MAX = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/ram_cache_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last-granted index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] next_ptr_s;
    logic [PW-1:0] idx_s;
    logic [N-1:0]  grant_s;
    logic          found_s;

    // Scan requesters starting just after the last-granted one; first hit wins.
    always_comb begin
        grant_s    = '0;
        next_ptr_s = ptr_r;
        found_s    = 1'b0;
        idx_s      = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = PW'((int'(ptr_r) + k) % N);
            if (en && !found_s && req[idx_s]) begin
                grant_s[idx_s] = 1'b1;
                next_ptr_s     = idx_s;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;

    // Pointer starts at N-1 so port 0 is served first after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= PW'(N - 1);
        end else if (found_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ram_cache_mp.sv
// Per-port one-entry read buffers sharing a single-port RAM; writes go straight through.
// Define RAM_CACHE_MP_STATS_EN to add the stat_hits / stat_misses counters.
module ram_cache_mp
    import ram_cache_mp_pkg::*;
#(
    parameter  int NPORTS = 2,
    parameter  int ADDR_W = 14,
    parameter  int DATA_W = 32,
    localparam int BEN_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_ren,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*BEN_W-1:0]  req_ben,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [NPORTS*DATA_W-1:0] req_rdata,
    output logic [NPORTS-1:0]        req_miss,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [BEN_W-1:0]         mem_ben,
    output logic                     mem_wen,
    input  logic [DATA_W-1:0]        mem_rdata
`ifdef RAM_CACHE_MP_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses
`endif
);

    localparam int PW = $clog2(NPORTS);

    if (NPORTS < NPORTS_MIN || NPORTS > NPORTS_MAX) begin : g_bad_nports
        $error("ram_cache_mp: NPORTS out of range");
    end

    state_t            state_r;
    logic [NPORTS-1:0] valid_r;
    logic [ADDR_W-1:0] tag_r  [NPORTS];
    logic [DATA_W-1:0] data_r [NPORTS];
    logic [ADDR_W-1:0] fill_addr_r;
    logic [PW-1:0]     fill_port_r;

    logic [NPORTS-1:0] is_wr_s;
    logic [NPORTS-1:0] hit_s;
    logic [NPORTS-1:0] need_s;
    logic [NPORTS-1:0] grant_s;
    logic              arb_en_s;
    logic              gnt_any_s;
    logic              gnt_wr_s;
    logic [PW-1:0]     gnt_idx_s;
    logic [ADDR_W-1:0] gnt_addr_s;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BEN_W-1:0]  ben
    );
        merge_bytes = old_data;
        for (int b = 0; b < BEN_W; b++) begin
            if (ben[b]) begin
                merge_bytes[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    endfunction

    // Per-port hit/need decode straight from the current request inputs.
    always_comb begin
        is_wr_s   = '0;
        hit_s     = '0;
        need_s    = '0;
        req_miss  = '0;
        req_rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            is_wr_s[p] = req_ren[p] && (req_ben[p*BEN_W +: BEN_W] != '0);
            hit_s[p]   = req_ren[p] && !is_wr_s[p] && valid_r[p]
                         && (tag_r[p] == req_addr[p*ADDR_W +: ADDR_W]);
            need_s[p]  = req_ren[p] && !hit_s[p];
            // A granted write completes in its own cycle, so only it drops the stall.
            req_miss[p] = !reset && need_s[p] && !(grant_s[p] && is_wr_s[p]);
            req_rdata[p*DATA_W +: DATA_W] = data_r[p];
        end
    end

    assign arb_en_s = (state_r == ST_IDLE) && !reset;

    rr_arbiter #(.N(NPORTS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en_s),
        .req   (need_s),
        .grant (grant_s)
    );

    // Turn the one-hot grant into the RAM command; the bus idles at zero.
    always_comb begin
        gnt_idx_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            gnt_idx_s = grant_s[p] ? PW'(p) : gnt_idx_s;
        end
        gnt_any_s  = |grant_s;
        gnt_wr_s   = gnt_any_s && is_wr_s[gnt_idx_s];
        gnt_addr_s = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
        mem_addr   = gnt_any_s ? gnt_addr_s : '0;
        mem_wen    = gnt_wr_s;
        mem_ben    = gnt_wr_s ? req_ben[gnt_idx_s*BEN_W +: BEN_W] : '0;
        mem_wdata  = gnt_wr_s ? req_wdata[gnt_idx_s*DATA_W +: DATA_W] : '0;
    end

    // FSM, fill capture and write-merge into every buffer holding the written word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            valid_r     <= '0;
            fill_addr_r <= '0;
            fill_port_r <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                tag_r[p]  <= '0;
                data_r[p] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_any_s && !gnt_wr_s) begin
                        state_r     <= ST_FILL;
                        fill_addr_r <= gnt_addr_s;
                        fill_port_r <= gnt_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                    for (int p = 0; p < NPORTS; p++) begin
                        if (gnt_wr_s && valid_r[p] && (tag_r[p] == gnt_addr_s)) begin
                            data_r[p] <= merge_bytes(data_r[p], mem_wdata, mem_ben);
                        end
                    end
                end
                ST_FILL: begin
                    // Tag comes from the issued address, not the port's current one.
                    state_r <= ST_IDLE;
                    for (int p = 0; p < NPORTS; p++) begin
                        if (PW'(p) == fill_port_r) begin
                            valid_r[p] <= 1'b1;
                            tag_r[p]   <= fill_addr_r;
                            data_r[p]  <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_CACHE_MP_STATS_EN
    logic [31:0] hits_r;
    logic [31:0] misses_r;

    // Hits add one per hitting port per cycle; misses count read grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else begin
            hits_r   <= hits_r + 32'($countones(hit_s));
            misses_r <= misses_r + {31'd0, (gnt_any_s && !gnt_wr_s)};
        end
    end

    assign stat_hits   = hits_r;
    assign stat_misses = misses_r;
`endif

endmodule

// File: tb/tb_ram_cache_mp.sv
// Directed bench for ram_cache_mp: stimulus queues expected acceptances/RAM writes,
// a negedge monitor pops and compares them.
module tb_ram_cache_mp;

    localparam int NP = 2;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_ren;
    logic [NP*AW-1:0] req_addr;
    logic [NP*BW-1:0] req_ben;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*DW-1:0] req_rdata;
    logic [NP-1:0]    req_miss;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [BW-1:0]    mem_ben;
    logic             mem_wen;
    logic [DW-1:0]    mem_rdata;
`ifdef RAM_CACHE_MP_STATS_EN
    logic [31:0]      stat_hits;
    logic [31:0]      stat_misses;
`endif

    always #5 clk = ~clk;

    ram_cache_mp #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_ren     (req_ren),
        .req_addr    (req_addr),
        .req_ben     (req_ben),
        .req_wdata   (req_wdata),
        .req_rdata   (req_rdata),
        .req_miss    (req_miss),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ben     (mem_ben),
        .mem_wen     (mem_wen),
        .mem_rdata   (mem_rdata)
`ifdef RAM_CACHE_MP_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [BW-1:0] ben;
        logic [DW-1:0] data;
    } wr_t;

    acc_t exp_q [NP][$];
    wr_t  mem_q [$];
    acc_t mon_acc;
    wr_t  mon_wr;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit [DW-1:0] ram     [0:(1<<AW)-1];
    bit          ram_wr  [0:(1<<AW)-1];

    function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
        case (a)
            14'h0005: ram_init = 32'hDEADBEEF;
            14'h0009: ram_init = 32'h12345678;
            14'h0020: ram_init = 32'hCAFEF00D;
            14'h0030: ram_init = 32'h30303030;
            14'h0031: ram_init = 32'h31313131;
            14'h0032: ram_init = 32'h32323232;
            14'h0050: ram_init = 32'h50505050;
            default:  ram_init = 32'h00000000;
        endcase
    endfunction

    function automatic logic [DW-1:0] ram_view(input logic [AW-1:0] a);
        ram_view = ram_wr[a] ? ram[a] : ram_init(a);
    endfunction

    // Single-port RAM model: byte-masked write, registered read (one-cycle latency).
    always @(posedge clk) begin
        logic [DW-1:0] cur;
        cur = ram_view(mem_addr);
        if (mem_wen) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_ben[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
            ram[mem_addr]    <= cur;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_view(mem_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every acceptance and every RAM write must match a queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                if (req_ren[p] && !req_miss[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL accept_p%0d: acceptance at cycle %0d, required none", p, cyc);
                    end else begin
                        mon_acc = exp_q[p].pop_front();
                        chk($sformatf("accept_cycle_p%0d", p), 64'(cyc), 64'(mon_acc.cyc));
                        chk($sformatf("rdata_p%0d", p), 64'(req_rdata[p*DW +: DW]), 64'(mon_acc.data));
                    end
                end
            end
            if (mem_wen) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_write: write at cycle %0d addr 0x%0h, required none", cyc, mem_addr);
                end else begin
                    mon_wr = mem_q.pop_front();
                    chk("mem_wr_cycle", 64'(cyc), 64'(mon_wr.cyc));
                    chk("mem_wr_addr", 64'(mem_addr), 64'(mon_wr.addr));
                    chk("mem_wr_ben", 64'(mem_ben), 64'(mon_wr.ben));
                    chk("mem_wr_data", 64'(mem_wdata), 64'(mon_wr.data));
                end
            end
        end
    end

    task automatic drive(input int p, input logic ren, input logic [AW-1:0] a,
                         input logic [BW-1:0] ben, input logic [DW-1:0] wd);
        req_ren[p]              = ren;
        req_addr[p*AW +: AW]    = a;
        req_ben[p*BW +: BW]     = ben;
        req_wdata[p*DW +: DW]   = wd;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_acc(input int p, input int c, input logic [DW-1:0] d);
        acc_t e;
        e.cyc  = c;
        e.data = d;
        exp_q[p].push_back(e);
    endtask

    task automatic expect_wr(input int c, input logic [AW-1:0] a, input logic [BW-1:0] ben,
                             input logic [DW-1:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.ben  = ben;
        w.data = d;
        mem_q.push_back(w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b1;
        req_ren   = '0;
        req_addr  = '0;
        req_ben   = '0;
        req_wdata = '0;

        // Reset: a pending read must not stall, bus quiet.
        drive(0, 1'b1, 14'h0005, 4'h0, 32'h0);
        tick(2);
        @(negedge clk);
        chk("reset_miss", 64'(req_miss), 64'(0));
        chk("reset_wen_ben", 64'({mem_wen, mem_ben}), 64'(0));

        // Read miss on port 0, hit two cycles later.
        tick(1);
        reset = 1'b0;
        t = cyc;
        expect_acc(0, t + 2, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_cmd_addr", 64'(mem_addr), 64'(14'h0005));
        chk("rd_cmd_wen_ben", 64'({mem_wen, mem_ben}), 64'(0));
        chk("miss_t", 64'(req_miss), 64'(2'b01));
        tick(1);
        @(negedge clk);
        chk("fill_bus_idle", 64'({mem_addr, mem_wen, mem_ben, mem_wdata}), 64'(0));
        chk("miss_t1", 64'(req_miss), 64'(2'b01));
        tick(2);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);

        // Simultaneous misses right after reset: port 0 first, port 1 two cycles later.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        drive(0, 1'b1, 14'h0009, 4'h0, 32'h0);
        drive(1, 1'b1, 14'h0020, 4'h0, 32'h0);
        t = cyc;
        expect_acc(0, t + 2, 32'h12345678);
        expect_acc(1, t + 4, 32'hCAFEF00D);
        tick(3);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);
        tick(2);
        drive(1, 1'b0, 14'h0, 4'h0, 32'h0);

        // Port 1 byte-writes a word port 0 has buffered; port 0 sees the merge.
        drive(0, 1'b1, 14'h0005, 4'h0, 32'h0);
        t = cyc;
        expect_acc(0, t + 2, 32'hDEADBEEF);
        expect_acc(0, t + 3, 32'hDEADBEEF);
        expect_acc(0, t + 4, 32'hDEADBEAA);
        expect_acc(1, t + 3, 32'hCAFEF00D);
        expect_wr(t + 3, 14'h0005, 4'h1, 32'h000000AA);
        tick(3);
        drive(1, 1'b1, 14'h0005, 4'h1, 32'h000000AA);
        tick(1);
        drive(1, 1'b0, 14'h0, 4'h0, 32'h0);
        tick(1);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);

        // Port 0 keeps missing (address moves during each fill) while port 1 streams writes.
        drive(0, 1'b1, 14'h0030, 4'h0, 32'h0);
        drive(1, 1'b1, 14'h0040, 4'hF, 32'h11111111);
        t = cyc;
        expect_acc(1, t + 2, 32'hCAFEF00D);
        expect_wr(t + 2, 14'h0040, 4'hF, 32'h11111111);
        expect_acc(1, t + 5, 32'hCAFEF00D);
        expect_wr(t + 5, 14'h0041, 4'hF, 32'h22222222);
        expect_acc(1, t + 8, 32'hCAFEF00D);
        expect_wr(t + 8, 14'h0042, 4'hF, 32'h33333333);
        expect_acc(0, t + 8, 32'h32323232);
        tick(1);
        drive(0, 1'b1, 14'h0031, 4'h0, 32'h0);
        tick(1);
        @(negedge clk);
        chk("fill_kept_issued_addr", 64'(req_rdata[DW-1:0]), 64'(32'h30303030));
        chk("moved_addr_misses", 64'(req_miss[0]), 64'(1));
        tick(1);
        drive(1, 1'b1, 14'h0041, 4'hF, 32'h22222222);
        tick(1);
        drive(0, 1'b1, 14'h0032, 4'h0, 32'h0);
        tick(2);
        drive(1, 1'b1, 14'h0042, 4'hF, 32'h33333333);
        tick(3);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 14'h0, 4'h0, 32'h0);

        // Reset during a fill discards it and clears every valid bit.
        drive(1, 1'b1, 14'h0050, 4'h0, 32'h0);
        t = cyc;
        tick(1);
        reset = 1'b1;
        drive(0, 1'b1, 14'h0032, 4'h0, 32'h0);
        @(negedge clk);
        chk("reset_in_fill_miss", 64'(req_miss), 64'(0));
        chk("reset_in_fill_wen", 64'({mem_wen, mem_ben}), 64'(0));
        tick(1);
        reset = 1'b0;
        expect_acc(0, t + 4, 32'h32323232);
        expect_acc(1, t + 6, 32'h50505050);
        @(negedge clk);
        chk("post_reset_both_miss", 64'(req_miss), 64'(2'b11));
        tick(3);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);
        tick(2);
        drive(1, 1'b0, 14'h0, 4'h0, 32'h0);

        // Three misses then four hit cycles (counter check when stats are built in).
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        drive(0, 1'b1, 14'h0005, 4'h0, 32'h0);
        t = cyc;
        expect_acc(0, t + 2, 32'hDEADBEAA);
        expect_acc(0, t + 5, 32'h12345678);
        expect_acc(0, t + 8, 32'hCAFEF00D);
        expect_acc(0, t + 9, 32'hCAFEF00D);
        tick(3);
        drive(0, 1'b1, 14'h0009, 4'h0, 32'h0);
        tick(3);
        drive(0, 1'b1, 14'h0020, 4'h0, 32'h0);
        tick(4);
        drive(0, 1'b0, 14'h0, 4'h0, 32'h0);
        @(negedge clk);
`ifdef RAM_CACHE_MP_STATS_EN
        chk("stat_misses", 64'(stat_misses), 64'(3));
        chk("stat_hits", 64'(stat_hits), 64'(4));
`endif
        chk("idle_bus", 64'({mem_addr, mem_wen, mem_ben, mem_wdata}), 64'(0));
        tick(2);

        for (int p = 0; p < NP; p++) begin
            while (exp_q[p].size() > 0) begin
                mon_acc = exp_q[p].pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_accept_p%0d: expected acceptance did not occur, required at cycle %0d", p, mon_acc.cyc);
            end
        end
        while (mem_q.size() > 0) begin
            mon_wr = mem_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_mem_write: expected write did not occur, required at cycle %0d addr 0x%0h", mon_wr.cyc, mon_wr.addr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
